// File: rtl/gcbp_vert_sched_if.sv
// Bundle between the line generator and the vertical sub-image scheduler.
// The master side drives line/frame strobes and reads scheduling results;
// the slave side is the scheduler itself.
interface gcbp_vert_sched_if #(
  parameter int C_NUM_VERT_SUBIMAGES = 4,
  parameter int C_NUM_HORI_SUBIMAGES = 4,
  parameter int C_ADDR_BITS          = 9
) ();
  logic                                             i_new_line;
  logic                                             i_new_frame;
  logic                                             i_line_valid;
  logic [2:0]                                       i_hori_subimage_cnt;
  logic [C_NUM_VERT_SUBIMAGES*C_NUM_HORI_SUBIMAGES-1:0] o_bram_write_enable;
  logic [C_ADDR_BITS-1:0]                           o_bram_write_addr;
  logic                                             o_row_active;
  logic [2:0]                                       o_vert_subimage_cnt;
  logic                                             o_row_done;
  logic                                             o_frame_done;
  logic                                             o_frame_err;
  logic [1:0]                                       o_next_frame_loc;
  logic [1:0]                                       o_curr_frame_loc;
  logic [1:0]                                       o_prev_frame_loc;

  modport master (
    output i_new_line, i_new_frame, i_line_valid, i_hori_subimage_cnt,
    input  o_bram_write_enable, o_bram_write_addr, o_row_active,
           o_vert_subimage_cnt, o_row_done, o_frame_done, o_frame_err,
           o_next_frame_loc, o_curr_frame_loc, o_prev_frame_loc
  );

  modport slave (
    input  i_new_line, i_new_frame, i_line_valid, i_hori_subimage_cnt,
    output o_bram_write_enable, o_bram_write_addr, o_row_active,
           o_vert_subimage_cnt, o_row_done, o_frame_done, o_frame_err,
           o_next_frame_loc, o_curr_frame_loc, o_prev_frame_loc
  );
endinterface

// File: rtl/gcbp_vert_sched.sv
// Vertical sub-image scheduler: walks the lines of a frame through the top
// edge, sub-image rows and inter-row gaps, generates per-sub-image BRAM write
// enables and addresses, and rotates three frame buffer slots per frame.
module gcbp_vert_sched #(
  parameter int C_NUM_VERT_SUBIMAGES = 4,
  parameter int C_NUM_HORI_SUBIMAGES = 4,
  parameter int C_SUBIMAGE_HEIGHT    = 64,
  parameter int C_VERT_EDGE          = 46,
  parameter int C_VERT_GAP           = 44,
  parameter int C_ADDR_BITS          = 9
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  gcbp_vert_sched_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_EDGE, S_ROW, S_GAP, S_DONE} state_t;

  localparam int          LP_NUM_EN    = C_NUM_VERT_SUBIMAGES * C_NUM_HORI_SUBIMAGES;
  localparam logic [7:0]  LP_EDGE      = 8'(C_VERT_EDGE);
  localparam logic [7:0]  LP_GAP       = 8'(C_VERT_GAP);
  localparam logic [7:0]  LP_H_LAST    = 8'(C_SUBIMAGE_HEIGHT - 1);
  localparam logic [2:0]  LP_LAST_ROW  = 3'(C_NUM_VERT_SUBIMAGES - 1);
  localparam logic [3:0]  LP_NUM_HORI  = 4'(C_NUM_HORI_SUBIMAGES);
  // A zero edge/gap skips straight into the next row.
  localparam state_t      LP_START     = (C_VERT_EDGE == 0) ? S_ROW : S_EDGE;
  localparam state_t      LP_AFTER_ROW = (C_VERT_GAP  == 0) ? S_ROW : S_GAP;

  state_t                 r_state, w_state;
  logic [7:0]             r_seg_cnt, w_seg_cnt;
  logic [2:0]             r_row, w_row;
  logic [1:0]             r_next_loc, r_curr_loc, r_prev_loc;
  logic [1:0]             w_next_loc, w_curr_loc, w_prev_loc;
  logic                   r_row_active, r_row_done, r_frame_done, r_frame_err;
  logic                   w_row_done, w_frame_done, w_frame_err;
  logic [C_ADDR_BITS-1:0] r_addr, w_addr;
  logic [LP_NUM_EN-1:0]   w_enable;

  // Next-state decode: only a line or frame strobe moves the schedule.
  always_comb begin
    w_state      = r_state;
    w_seg_cnt    = r_seg_cnt;
    w_row        = r_row;
    w_next_loc   = r_next_loc;
    w_curr_loc   = r_curr_loc;
    w_prev_loc   = r_prev_loc;
    w_row_done   = 1'b0;
    w_frame_done = 1'b0;
    w_frame_err  = 1'b0;
    if (bus.i_new_frame) begin
      // A frame strobe is line 0 even when it coincides with a line strobe.
      w_frame_err = (r_state == S_EDGE) || (r_state == S_ROW) || (r_state == S_GAP);
      w_state     = LP_START;
      w_seg_cnt   = 8'd0;
      w_row       = 3'd0;
    end else if (bus.i_new_line) begin
      case (r_state)
        S_EDGE: begin
          if (r_seg_cnt + 8'd1 == LP_EDGE) begin
            w_state   = S_ROW;
            w_seg_cnt = 8'd0;
            w_row     = 3'd0;
          end else begin
            w_seg_cnt = r_seg_cnt + 8'd1;
          end
        end
        S_ROW: begin
          if (r_seg_cnt == LP_H_LAST) begin
            w_row_done = 1'b1;
            w_seg_cnt  = 8'd0;
            if (r_row == LP_LAST_ROW) begin
              // Frame complete: the filled slot becomes current, the oldest
              // slot is recycled as the next write target.
              w_state      = S_DONE;
              w_frame_done = 1'b1;
              w_prev_loc   = r_curr_loc;
              w_curr_loc   = r_next_loc;
              w_next_loc   = r_prev_loc;
            end else begin
              w_row   = r_row + 3'd1;
              w_state = LP_AFTER_ROW;
            end
          end else begin
            w_seg_cnt = r_seg_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (r_seg_cnt + 8'd1 == LP_GAP) begin
            w_state   = S_ROW;
            w_seg_cnt = 8'd0;
          end else begin
            w_seg_cnt = r_seg_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
    w_addr = C_ADDR_BITS'(32'(w_next_loc) * 32'(C_SUBIMAGE_HEIGHT) + 32'(w_seg_cnt));
  end

  // State and registered outputs; everything but the enables lags one cycle.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= S_IDLE;
      r_seg_cnt    <= 8'd0;
      r_row        <= 3'd0;
      r_next_loc   <= 2'd0;
      r_curr_loc   <= 2'd1;
      r_prev_loc   <= 2'd2;
      r_row_active <= 1'b0;
      r_row_done   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_addr       <= '0;
    end else begin
      r_state      <= w_state;
      r_seg_cnt    <= w_seg_cnt;
      r_row        <= w_row;
      r_next_loc   <= w_next_loc;
      r_curr_loc   <= w_curr_loc;
      r_prev_loc   <= w_prev_loc;
      r_row_active <= (w_state == S_ROW);
      r_row_done   <= w_row_done;
      r_frame_done <= w_frame_done;
      r_frame_err  <= w_frame_err;
      r_addr       <= w_addr;
    end
  end

  // One-hot write enable for the sub-image the current word belongs to.
  always_comb begin
    w_enable = '0;
    if (r_row_active && bus.i_line_valid &&
        ({1'b0, bus.i_hori_subimage_cnt} < LP_NUM_HORI)) begin
      for (int b = 0; b < LP_NUM_EN; b++) begin
        if (b == int'(r_row) * C_NUM_HORI_SUBIMAGES + int'(bus.i_hori_subimage_cnt))
          w_enable[b] = 1'b1;
      end
    end
  end

  assign bus.o_bram_write_enable = w_enable;
  assign bus.o_bram_write_addr   = r_addr;
  assign bus.o_row_active        = r_row_active;
  assign bus.o_vert_subimage_cnt = r_row;
  assign bus.o_row_done          = r_row_done;
  assign bus.o_frame_done        = r_frame_done;
  assign bus.o_frame_err         = r_frame_err;
  assign bus.o_next_frame_loc    = r_next_loc;
  assign bus.o_curr_frame_loc    = r_curr_loc;
  assign bus.o_prev_frame_loc    = r_prev_loc;

endmodule

// File: tb/tb_gcbp_vert_sched.sv
// Directed bench for gcbp_vert_sched: default geometry on one instance and a
// minimal geometry (no edge, no gap, 2-line rows, 2 rows) on a second one.
module tb_gcbp_vert_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcbp_vert_sched_if #(.C_NUM_VERT_SUBIMAGES(4), .C_NUM_HORI_SUBIMAGES(4), .C_ADDR_BITS(9)) bus_a ();
  gcbp_vert_sched_if #(.C_NUM_VERT_SUBIMAGES(2), .C_NUM_HORI_SUBIMAGES(4), .C_ADDR_BITS(9)) bus_b ();

  gcbp_vert_sched u_dut_a (
    .i_clk    (clk),
    .i_resetn (rst_n),
    .bus      (bus_a.slave)
  );

  gcbp_vert_sched #(
    .C_NUM_VERT_SUBIMAGES (2),
    .C_NUM_HORI_SUBIMAGES (4),
    .C_SUBIMAGE_HEIGHT    (2),
    .C_VERT_EDGE          (0),
    .C_VERT_GAP           (0),
    .C_ADDR_BITS          (9)
  ) u_dut_b (
    .i_clk    (clk),
    .i_resetn (rst_n),
    .bus      (bus_b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic line_a(input bit nf, input bit nl);
    bus_a.i_new_frame = nf;
    bus_a.i_new_line  = nl;
    @(posedge clk); #1;
    bus_a.i_new_frame = 1'b0;
    bus_a.i_new_line  = 1'b0;
  endtask

  task automatic line_b(input bit nf, input bit nl);
    bus_b.i_new_frame = nf;
    bus_b.i_new_line  = nl;
    @(posedge clk); #1;
    bus_b.i_new_frame = 1'b0;
    bus_b.i_new_line  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.i_new_line = 1'b0; bus_a.i_new_frame = 1'b0;
    bus_a.i_line_valid = 1'b1; bus_a.i_hori_subimage_cnt = 3'd0;
    bus_b.i_new_line = 1'b0; bus_b.i_new_frame = 1'b0;
    bus_b.i_line_valid = 1'b0; bus_b.i_hori_subimage_cnt = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus_a.o_row_active !== 1'b0) begin n_bad++; $display("FAIL reset_row_active got %b want 0", bus_a.o_row_active); end
    n_cmp++; if (bus_a.o_bram_write_enable !== 16'h0000) begin n_bad++; $display("FAIL reset_enable got %h want 0000", bus_a.o_bram_write_enable); end
    n_cmp++; if (bus_a.o_bram_write_addr !== 9'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", bus_a.o_bram_write_addr); end
    n_cmp++; if ({bus_a.o_row_done, bus_a.o_frame_done, bus_a.o_frame_err} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {bus_a.o_row_done, bus_a.o_frame_done, bus_a.o_frame_err}); end
    n_cmp++; if (bus_a.o_vert_subimage_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_vcnt got %0d want 0", bus_a.o_vert_subimage_cnt); end
    n_cmp++; if ({bus_a.o_next_frame_loc, bus_a.o_curr_frame_loc, bus_a.o_prev_frame_loc} !== 6'b00_01_10) begin n_bad++; $display("FAIL reset_locs got %b want 000110", {bus_a.o_next_frame_loc, bus_a.o_curr_frame_loc, bus_a.o_prev_frame_loc}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Idle ignores line strobes.
    for (int i = 0; i < 3; i++) line_a(1'b0, 1'b1);
    n_cmp++; if (bus_a.o_row_active !== 1'b0) begin n_bad++; $display("FAIL idle_ignore_line got %b want 0", bus_a.o_row_active); end
    n_cmp++; if (bus_a.o_bram_write_addr !== 9'd0) begin n_bad++; $display("FAIL idle_addr got %0d want 0", bus_a.o_bram_write_addr); end
    bus_a.i_line_valid = 1'b0;
  endtask

  // Full 480-line frame on the default geometry; rows at 46+108k .. 109+108k.
  task automatic test_full_frame(input bit nl_with_frame, input logic [1:0] next0,
                                 input logic [5:0] locs_after);
    bit exp_act, exp_rd, exp_fd;
    int exp_row, exp_seg;
    for (int l = 0; l < 480; l++) begin
      line_a(l == 0, (l == 0) ? nl_with_frame : 1'b1);
      exp_act = (l >= 46 && l <= 109) || (l >= 154 && l <= 217) ||
                (l >= 262 && l <= 325) || (l >= 370 && l <= 433);
      exp_rd  = (l == 110) || (l == 218) || (l == 326) || (l == 434);
      exp_fd  = (l == 434);
      exp_row = (l - 46) / 108;
      exp_seg = (l - 46) % 108;
      n_cmp++; if (bus_a.o_row_active !== exp_act) begin n_bad++; $display("FAIL frame_row_active line %0d got %b want %b", l, bus_a.o_row_active, exp_act); end
      n_cmp++; if (bus_a.o_row_done !== exp_rd) begin n_bad++; $display("FAIL frame_row_done line %0d got %b want %b", l, bus_a.o_row_done, exp_rd); end
      n_cmp++; if (bus_a.o_frame_done !== exp_fd) begin n_bad++; $display("FAIL frame_done line %0d got %b want %b", l, bus_a.o_frame_done, exp_fd); end
      n_cmp++; if (bus_a.o_frame_err !== 1'b0) begin n_bad++; $display("FAIL frame_err line %0d got %b want 0", l, bus_a.o_frame_err); end
      if (exp_act) begin
        n_cmp++; if (bus_a.o_vert_subimage_cnt !== 3'(exp_row)) begin n_bad++; $display("FAIL frame_vcnt line %0d got %0d want %0d", l, bus_a.o_vert_subimage_cnt, exp_row); end
        n_cmp++; if (bus_a.o_bram_write_addr !== 9'(next0 * 64 + exp_seg)) begin n_bad++; $display("FAIL frame_addr line %0d got %0d want %0d", l, bus_a.o_bram_write_addr, next0 * 64 + exp_seg); end
      end
      if (l == 300) begin
        bus_a.i_line_valid = 1'b1; bus_a.i_hori_subimage_cnt = 3'd3; #1;
        n_cmp++; if (bus_a.o_bram_write_enable !== 16'h0800) begin n_bad++; $display("FAIL en_row2_h3 got %h want 0800", bus_a.o_bram_write_enable); end
        bus_a.i_hori_subimage_cnt = 3'd5; #1;
        n_cmp++; if (bus_a.o_bram_write_enable !== 16'h0000) begin n_bad++; $display("FAIL en_hori_oob got %h want 0000", bus_a.o_bram_write_enable); end
        bus_a.i_line_valid = 1'b0; bus_a.i_hori_subimage_cnt = 3'd3; #1;
        n_cmp++; if (bus_a.o_bram_write_enable !== 16'h0000) begin n_bad++; $display("FAIL en_invalid got %h want 0000", bus_a.o_bram_write_enable); end
      end
      if (l == 130) begin
        bus_a.i_line_valid = 1'b1; bus_a.i_hori_subimage_cnt = 3'd3; #1;
        n_cmp++; if (bus_a.o_bram_write_enable !== 16'h0000) begin n_bad++; $display("FAIL en_gap got %h want 0000", bus_a.o_bram_write_enable); end
        bus_a.i_line_valid = 1'b0;
      end
    end
    n_cmp++; if ({bus_a.o_next_frame_loc, bus_a.o_curr_frame_loc, bus_a.o_prev_frame_loc} !== locs_after) begin n_bad++; $display("FAIL frame_rotate got %b want %b", {bus_a.o_next_frame_loc, bus_a.o_curr_frame_loc, bus_a.o_prev_frame_loc}, locs_after); end
  endtask

  // Second frame driven by a lone frame strobe; row 0 writes to slot 2.
  task automatic test_frame2_addr();
    line_a(1'b1, 1'b0);
    n_cmp++; if (bus_a.o_frame_err !== 1'b0) begin n_bad++; $display("FAIL f2_no_err got %b want 0", bus_a.o_frame_err); end
    for (int l = 1; l <= 46; l++) line_a(1'b0, 1'b1);
    n_cmp++; if (bus_a.o_row_active !== 1'b1) begin n_bad++; $display("FAIL f2_row_active got %b want 1", bus_a.o_row_active); end
    n_cmp++; if (bus_a.o_bram_write_addr !== 9'd128) begin n_bad++; $display("FAIL f2_addr got %0d want 128", bus_a.o_bram_write_addr); end
  endtask

  // Frame strobe at line 200 aborts the frame.
  task automatic test_frame_err();
    for (int l = 47; l < 200; l++) line_a(1'b0, 1'b1);
    line_a(1'b1, 1'b0);
    n_cmp++; if (bus_a.o_frame_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse got %b want 1", bus_a.o_frame_err); end
    n_cmp++; if (bus_a.o_row_done !== 1'b0) begin n_bad++; $display("FAIL err_no_row_done got %b want 0", bus_a.o_row_done); end
    n_cmp++; if (bus_a.o_frame_done !== 1'b0) begin n_bad++; $display("FAIL err_no_frame_done got %b want 0", bus_a.o_frame_done); end
    n_cmp++; if (bus_a.o_row_active !== 1'b0) begin n_bad++; $display("FAIL err_row_active got %b want 0", bus_a.o_row_active); end
    n_cmp++; if ({bus_a.o_next_frame_loc, bus_a.o_curr_frame_loc, bus_a.o_prev_frame_loc} !== 6'b10_00_01) begin n_bad++; $display("FAIL err_no_rotate got %b want 100001", {bus_a.o_next_frame_loc, bus_a.o_curr_frame_loc, bus_a.o_prev_frame_loc}); end
    line_a(1'b0, 1'b1);
    n_cmp++; if (bus_a.o_frame_err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle got %b want 0", bus_a.o_frame_err); end
    for (int l = 2; l <= 45; l++) line_a(1'b0, 1'b1);
    n_cmp++; if (bus_a.o_row_active !== 1'b0) begin n_bad++; $display("FAIL err_line45 got %b want 0", bus_a.o_row_active); end
    line_a(1'b0, 1'b1);
    n_cmp++; if (bus_a.o_row_active !== 1'b1) begin n_bad++; $display("FAIL err_line46 got %b want 1", bus_a.o_row_active); end
    n_cmp++; if (bus_a.o_vert_subimage_cnt !== 3'd0) begin n_bad++; $display("FAIL err_vcnt got %0d want 0", bus_a.o_vert_subimage_cnt); end
  endtask

  // Minimal geometry on the second instance, lines back to back.
  task automatic test_back_to_back();
    logic [2:0] exp_cnt [5]  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    logic       exp_act [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_rd  [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_fd  [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [8:0] exp_adr [4]  = '{9'd0, 9'd1, 9'd0, 9'd1};
    for (int l = 0; l < 5; l++) begin
      line_b(l == 0, 1'b1);
      n_cmp++; if (bus_b.o_row_active !== exp_act[l]) begin n_bad++; $display("FAIL small_active line %0d got %b want %b", l, bus_b.o_row_active, exp_act[l]); end
      n_cmp++; if (bus_b.o_row_done !== exp_rd[l]) begin n_bad++; $display("FAIL small_row_done line %0d got %b want %b", l, bus_b.o_row_done, exp_rd[l]); end
      n_cmp++; if (bus_b.o_frame_done !== exp_fd[l]) begin n_bad++; $display("FAIL small_frame_done line %0d got %b want %b", l, bus_b.o_frame_done, exp_fd[l]); end
      if (l < 4) begin
        n_cmp++; if (bus_b.o_vert_subimage_cnt !== exp_cnt[l]) begin n_bad++; $display("FAIL small_vcnt line %0d got %0d want %0d", l, bus_b.o_vert_subimage_cnt, exp_cnt[l]); end
        n_cmp++; if (bus_b.o_bram_write_addr !== exp_adr[l]) begin n_bad++; $display("FAIL small_addr line %0d got %0d want %0d", l, bus_b.o_bram_write_addr, exp_adr[l]); end
      end
    end
    n_cmp++; if ({bus_b.o_next_frame_loc, bus_b.o_curr_frame_loc, bus_b.o_prev_frame_loc} !== 6'b10_00_01) begin n_bad++; $display("FAIL small_rotate got %b want 100001", {bus_b.o_next_frame_loc, bus_b.o_curr_frame_loc, bus_b.o_prev_frame_loc}); end
  endtask

  // Asynchronous reset in row 1, then a clean frame.
  task automatic test_reset_mid();
    for (int l = 47; l <= 160; l++) line_a(1'b0, 1'b1);
    n_cmp++; if (bus_a.o_vert_subimage_cnt !== 3'd1) begin n_bad++; $display("FAIL mid_pre_vcnt got %0d want 1", bus_a.o_vert_subimage_cnt); end
    bus_a.i_line_valid = 1'b1; bus_a.i_hori_subimage_cnt = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_a.o_row_active !== 1'b0) begin n_bad++; $display("FAIL mid_row_active got %b want 0", bus_a.o_row_active); end
    n_cmp++; if (bus_a.o_bram_write_enable !== 16'h0000) begin n_bad++; $display("FAIL mid_enable got %h want 0000", bus_a.o_bram_write_enable); end
    n_cmp++; if (bus_a.o_vert_subimage_cnt !== 3'd0) begin n_bad++; $display("FAIL mid_vcnt got %0d want 0", bus_a.o_vert_subimage_cnt); end
    n_cmp++; if (bus_a.o_bram_write_addr !== 9'd0) begin n_bad++; $display("FAIL mid_addr got %0d want 0", bus_a.o_bram_write_addr); end
    n_cmp++; if ({bus_a.o_next_frame_loc, bus_a.o_curr_frame_loc, bus_a.o_prev_frame_loc} !== 6'b00_01_10) begin n_bad++; $display("FAIL mid_locs got %b want 000110", {bus_a.o_next_frame_loc, bus_a.o_curr_frame_loc, bus_a.o_prev_frame_loc}); end
    bus_a.i_line_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_full_frame(1'b1, 2'd0, 6'b10_00_01);
  endtask

  initial begin
    test_reset();
    test_full_frame(1'b1, 2'd0, 6'b10_00_01);
    test_frame2_addr();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gcbp_vert_sched.md
GCBP_VERT_SCHED -- requirements
Module: gcbp_vert_sched

Interface
REQ-001 Parameter C_NUM_VERT_SUBIMAGES, default 4: sub-image rows per frame (1..8).
REQ-002 Parameter C_NUM_HORI_SUBIMAGES, default 4: sub-images per row (1..8).
REQ-003 Parameter C_SUBIMAGE_HEIGHT, default 64: lines per sub-image (2..128).
REQ-004 Parameter C_VERT_EDGE, default 46: lines from frame top to row 0 (0..255).
REQ-005 Parameter C_VERT_GAP, default 44: lines between consecutive rows (0..255).
REQ-006 Parameter C_ADDR_BITS, default 9: BRAM write address width; 2^C_ADDR_BITS SHALL be >= 3*C_SUBIMAGE_HEIGHT.
REQ-007 i_clk  in  1  sole clock; all state on rising edge.
REQ-008 i_resetn  in  1  asynchronous, active-low reset.
REQ-009 i_new_line  in  1  one-cycle pulse, start of a video line.
REQ-010 i_new_frame  in  1  one-cycle pulse, start of line 0 of a frame.
REQ-011 i_line_valid  in  1  line generator word valid.
REQ-012 i_hori_subimage_cnt  in  3  horizontal sub-image index of current word.
REQ-013 o_bram_write_enable  out  C_NUM_VERT_SUBIMAGES*C_NUM_HORI_SUBIMAGES  one-hot BRAM write enables.
REQ-014 o_bram_write_addr  out  C_ADDR_BITS  BRAM write address.
REQ-015 o_row_active  out  1  current line lies inside a sub-image row.
REQ-016 o_vert_subimage_cnt  out  3  current row index.
REQ-017 o_row_done  out  1  one-cycle pulse, row completed.
REQ-018 o_frame_done  out  1  one-cycle pulse, all rows of frame completed.
REQ-019 o_frame_err  out  1  one-cycle pulse, frame aborted early.
REQ-020 o_next_frame_loc, o_curr_frame_loc, o_prev_frame_loc  out  2 each  buffer slot (0..2) of each frame type.

Function
REQ-021 FSM states: S_IDLE, S_EDGE, S_ROW, S_GAP, S_DONE; state, line-in-segment counter r_seg_cnt and row counter SHALL update only on i_new_line or i_new_frame.
REQ-022 S_IDLE: ignore i_new_line; on i_new_frame go to S_EDGE (or S_ROW, row 0, if C_VERT_EDGE=0), r_seg_cnt=0.
REQ-023 i_new_frame SHALL denote line 0 whether or not i_new_line is asserted that cycle; simultaneous pulses count as one line.
REQ-024 S_EDGE: on i_new_line increment r_seg_cnt; when incremented value equals C_VERT_EDGE go to S_ROW, row 0, r_seg_cnt=0.
REQ-025 S_ROW: on i_new_line with r_seg_cnt = C_SUBIMAGE_HEIGHT-1, pulse o_row_done; if last row go to S_DONE, else increment row and go to S_GAP (S_ROW with r_seg_cnt=0 if C_VERT_GAP=0); otherwise increment r_seg_cnt.
REQ-026 S_GAP: on i_new_line increment r_seg_cnt; when equal to C_VERT_GAP go to S_ROW, r_seg_cnt=0.
REQ-027 Entering S_DONE SHALL pulse o_frame_done in the same cycle as the final o_row_done and rotate slots: prev<=curr, curr<=next, next<=old prev.
REQ-028 S_DONE: ignore i_new_line; i_new_frame restarts as in REQ-022.
REQ-029 i_new_frame in S_EDGE, S_ROW or S_GAP SHALL pulse o_frame_err, skip rotation and row_done, and restart as REQ-022.
REQ-030 All outputs except o_bram_write_enable SHALL be registered; they reflect the line started by a pulse from the following cycle (latency 1).
REQ-031 o_row_active SHALL be 1 exactly while in S_ROW.
REQ-032 o_bram_write_addr = o_next_frame_loc*C_SUBIMAGE_HEIGHT + r_seg_cnt, truncated to C_ADDR_BITS.
REQ-033 o_bram_write_enable bit (o_vert_subimage_cnt*C_NUM_HORI_SUBIMAGES + i_hori_subimage_cnt) SHALL be 1 iff o_row_active and i_line_valid and i_hori_subimage_cnt < C_NUM_HORI_SUBIMAGES; all other bits 0 (combinational).

Reset
REQ-034 While i_resetn=0: state S_IDLE, counters 0, o_row_active/o_row_done/o_frame_done/o_frame_err/o_bram_write_enable 0, o_bram_write_addr 0, o_vert_subimage_cnt 0, next/curr/prev loc = 0/1/2.
REQ-035 Reset mid-frame SHALL discard progress; first frame after release starts from S_IDLE with no o_frame_err.

Verification
REQ-036 Defaults, 480-line frame: o_row_active high for lines 46-109, 154-217, 262-325, 370-433, with o_vert_subimage_cnt 0..3; o_row_done at line starts 110, 218, 326, 434.
REQ-037 Defaults, line 434 start -> o_frame_done and o_row_done both pulse; locs go 0/1/2 -> 2/0/1; frame 2 line 46 address = 128.
REQ-038 i_new_frame at line 200 of frame -> o_frame_err 1 cycle, no rotation, new frame row 0 begins at the 46th line after it.
REQ-039 Row 2, i_hori_subimage_cnt=3, i_line_valid=1 -> only enable bit 11; i_line_valid=0 or in S_GAP -> all 0.
REQ-040 C_VERT_EDGE=0, C_VERT_GAP=0, C_SUBIMAGE_HEIGHT=2, C_NUM_VERT_SUBIMAGES=2 -> rows active lines 0-1 and 2-3, o_frame_done at line 4 start.
REQ-041 Assert i_resetn=0 during row 1 -> outputs at REQ-034 values asynchronously; next frame runs as REQ-036.
